// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: make/break/E0 sequences to game-control
// levels, rising-edge pulses and a last-completed-code record.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       clear_keys,
    output logic       key_left,
    output logic       key_right,
    output logic       key_jump,
    output logic       key_start,
    output logic       jump_pressed,
    output logic       start_pressed,
    output logic       code_valid,
    output logic [7:0] last_code,
    output logic       last_ext,
    output logic       last_break
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic hl_q, hl_d, hr_q, hr_d, hsp_q, hsp_d, hup_q, hup_d, hen_q, hen_d;
    logic jp_q, jp_d, sp_q, sp_d;
    logic cv_q, cv_d;
    logic [7:0] lc_q, lc_d;
    logic le_q, le_d, lb_q, lb_d;
    logic done, is_ext, is_brk, ignored;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            hl_q    <= 1'b0;
            hr_q    <= 1'b0;
            hsp_q   <= 1'b0;
            hup_q   <= 1'b0;
            hen_q   <= 1'b0;
            jp_q    <= 1'b0;
            sp_q    <= 1'b0;
            cv_q    <= 1'b0;
            lc_q    <= 8'h00;
            le_q    <= 1'b0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            hsp_q   <= hsp_d;
            hup_q   <= hup_d;
            hen_q   <= hen_d;
            jp_q    <= jp_d;
            sp_q    <= sp_d;
            cv_q    <= cv_d;
            lc_q    <= lc_d;
            le_q    <= le_d;
            lb_q    <= lb_d;
        end
    end

    // Sequencer: prefixes advance the state, the final byte completes.
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        done    = 1'b0;
        is_ext  = 1'b0;
        is_brk  = 1'b0;
        ignored = received_data inside {8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF};
        if (received_data_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (received_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (received_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (!ignored) begin
                        done = 1'b1;
                    end
                end
                S_EXT: begin
                    if (received_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (received_data != 8'hE0) begin
                        done    = 1'b1;
                        is_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    done    = 1'b1;
                    is_brk  = 1'b1;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    done    = 1'b1;
                    is_ext  = 1'b1;
                    is_brk  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    always_comb begin
        hl_d  = hl_q;
        hr_d  = hr_q;
        hsp_d = hsp_q;
        hup_d = hup_q;
        hen_d = hen_q;
        if (done) begin
            if (is_ext) begin
                case (received_data)
                    8'h6B:   hl_d  = !is_brk;
                    8'h74:   hr_d  = !is_brk;
                    8'h75:   hup_d = !is_brk;
                    default: ;
                endcase
            end else begin
                case (received_data)
                    8'h29:   hsp_d = !is_brk;
                    8'h5A:   hen_d = !is_brk;
                    default: ;
                endcase
            end
        end
        // Clearing overrides a make landing in the same cycle.
        if (clear_keys) begin
            hl_d  = 1'b0;
            hr_d  = 1'b0;
            hsp_d = 1'b0;
            hup_d = 1'b0;
            hen_d = 1'b0;
        end
        jp_d = (hsp_d | hup_d) & ~(hsp_q | hup_q);
        sp_d = hen_d & ~hen_q;
        cv_d = done;
        lc_d = done ? received_data : lc_q;
        le_d = done ? is_ext : le_q;
        lb_d = done ? is_brk : lb_q;
    end

    assign key_left      = hl_q;
    assign key_right     = hr_q;
    assign key_jump      = hsp_q | hup_q;
    assign key_start     = hen_q;
    assign jump_pressed  = jp_q;
    assign start_pressed = sp_q;
    assign code_valid    = cv_q;
    assign last_code     = lc_q;
    assign last_ext      = le_q;
    assign last_break    = lb_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte sequences queue
// expected completions; a monitor checks each code_valid against them.
module tb_ps2_key_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       clear_keys;
    logic       key_left, key_right, key_jump, key_start;
    logic       jump_pressed, start_pressed, code_valid;
    logic [7:0] last_code;
    logic       last_ext, last_break;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       l;
        logic       r;
        logic       j;
        logic       s;
        logic       jp;
        logic       sp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_W     (5)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .clear_keys      (clear_keys),
        .key_left        (key_left),
        .key_right       (key_right),
        .key_jump        (key_jump),
        .key_start       (key_start),
        .jump_pressed    (jump_pressed),
        .start_pressed   (start_pressed),
        .code_valid      (code_valid),
        .last_code       (last_code),
        .last_ext        (last_ext),
        .last_break      (last_break)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic exp_t actual();
        exp_t a;
        a.code = last_code;
        a.ext  = last_ext;
        a.brk  = last_break;
        a.l    = key_left;
        a.r    = key_right;
        a.j    = key_jump;
        a.s    = key_start;
        a.jp   = jump_pressed;
        a.sp   = start_pressed;
        return a;
    endfunction

    always @(negedge CLOCK_50) begin
        if (code_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_code_valid got=%h want=none",
                         actual());
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (actual() !== e) begin
                    n_fail++;
                    $display("FAIL completion got=%h want=%h", actual(), e);
                end
            end
        end else if (jump_pressed || start_pressed) begin
            n_checks++;
            n_fail++;
            $display("FAIL stray_pulse got jp=%b sp=%b want 0 0",
                     jump_pressed, start_pressed);
        end
    end

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic clr);
        received_data    = b;
        received_data_en = 1'b1;
        clear_keys       = clr;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
        clear_keys       = 1'b0;
    endtask

    // Queue the expected completion, then strobe the completing byte.
    task automatic sx(input logic [7:0] b, input logic clr,
                      input logic [15:0] e);
        exp_q.push_back(exp_t'(e));
        send(b, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        clear_keys       = 1'b0;
        idle(3);
        check("reset_outputs", 16'(actual()) | {15'd0, code_valid}, 16'h0);
        reset = 1'b0;
        idle(1);

        // space make / break
        sx(8'h29, 1'b0, {8'h29, 8'b00_0010_10});
        send(8'hF0, 1'b0);
        sx(8'h29, 1'b0, {8'h29, 8'b01_0000_00});

        // arrows: left, right, release left, release right
        send(8'hE0, 1'b0);
        sx(8'h6B, 1'b0, {8'h6B, 8'b10_1000_00});
        send(8'hE0, 1'b0);
        sx(8'h74, 1'b0, {8'h74, 8'b10_1100_00});
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        sx(8'h6B, 1'b0, {8'h6B, 8'b11_0100_00});
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        sx(8'h74, 1'b0, {8'h74, 8'b11_0000_00});

        // keypad 4 is not left; enter with typematic repeat
        sx(8'h6B, 1'b0, {8'h6B, 8'b00_0000_00});
        sx(8'h5A, 1'b0, {8'h5A, 8'b00_0001_01});
        sx(8'h5A, 1'b0, {8'h5A, 8'b00_0001_00});
        sx(8'h5A, 1'b0, {8'h5A, 8'b00_0001_00});
        send(8'hF0, 1'b0);
        sx(8'h5A, 1'b0, {8'h5A, 8'b01_0000_00});

        // housekeeping codes complete nothing
        send(8'hFA, 1'b0);
        send(8'hAA, 1'b0);
        idle(1);
        check("ignored_keeps_last", {last_code, 6'd0, last_ext, last_break},
              {8'h5A, 6'd0, 1'b0, 1'b1});

        // E0 abandoned after 16 quiet cycles
        send(8'hE0, 1'b0);
        idle(16);
        sx(8'h75, 1'b0, {8'h75, 8'b00_0000_00});

        // E0 survives 15 quiet cycles
        send(8'hE0, 1'b0);
        idle(15);
        sx(8'h75, 1'b0, {8'h75, 8'b10_0010_10});
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        sx(8'h75, 1'b0, {8'h75, 8'b11_0000_00});

        // F0 abandoned: following 29 is a make
        send(8'hF0, 1'b0);
        idle(16);
        sx(8'h29, 1'b0, {8'h29, 8'b00_0010_10});

        // up while space held: no second pulse
        send(8'hE0, 1'b0);
        sx(8'h75, 1'b0, {8'h75, 8'b10_0010_00});

        // clear_keys together with enter make
        sx(8'h5A, 1'b1, {8'h5A, 8'b00_0000_00});
        idle(1);
        check("levels_after_clear",
              {12'd0, key_left, key_right, key_jump, key_start}, 16'h0);

        // reset between F0 and 29 with space held
        sx(8'h29, 1'b0, {8'h29, 8'b00_0010_10});
        send(8'hF0, 1'b0);
        reset = 1'b1;
        idle(2);
        check("midseq_reset_outputs", 16'(actual()) | {15'd0, code_valid},
              16'h0);
        reset = 1'b0;
        sx(8'h29, 1'b0, {8'h29, 8'b00_0010_10});

        idle(4);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
